// File: rtl/water_reservoir_controller.sv
// Three-sensor reservoir level controller with optional sensor debounce filter.
// Optional FAULT state for inconsistent sensor patterns: define FAULT_DETECT_EN.
module water_reservoir_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  output logic FR1,
  output logic FR2,
  output logic FR3,
  output logic AFR
);

  typedef enum logic [2:0] {
    LVL_HIGH = 3'd0,
    LVL_MID  = 3'd1,
    LVL_LOW  = 3'd2,
`ifdef FAULT_DETECT_EN
    LVL_CRIT = 3'd3,
    FAULT    = 3'd4
`else
    LVL_CRIT = 3'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  fr_q, fr_d;   // bit 0 = FR1, bit 1 = FR2, bit 2 = FR3
  logic        afr_q, afr_d;
  logic [2:0]  sens_s;
  logic [2:0]  acc_vec_s;
  logic        accept_s;

  assign sens_s = {S3, S2, S1};

  function automatic state_t decode_level(input logic [2:0] v);
    state_t st;
    case (v)
      3'b111:  st = LVL_HIGH;
      3'b011:  st = LVL_MID;
      3'b001:  st = LVL_LOW;
      3'b000:  st = LVL_CRIT;
      default: begin
`ifdef FAULT_DETECT_EN
        st = FAULT;
`else
        // Inconsistent pattern: the lowest dry sensor decides the level.
        if (!v[0]) begin
          st = LVL_CRIT;
        end else if (!v[1]) begin
          st = LVL_LOW;
        end else begin
          st = LVL_MID;
        end
`endif
      end
    endcase
    return st;
  endfunction

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nofilt
      assign accept_s  = 1'b1;
      assign acc_vec_s = sens_s;
    end else begin : g_filt
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);
      logic [2:0]    samp_q;
      logic [CW-1:0] cnt_q;

      // Sample register and stability counter; a change restarts the count.
      always_ff @(posedge clk) begin
        if (!reset) begin
          samp_q <= 3'b111;
          cnt_q  <= '0;
        end else begin
          samp_q <= sens_s;
          if (sens_s != samp_q) begin
            cnt_q <= '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
      end

      // Accept on the DEBOUNCE_CYCLES-th consecutive identical sample.
      assign accept_s  = (sens_s == samp_q) && (cnt_q == CNT_ARM);
      assign acc_vec_s = sens_s;
    end
  endgenerate

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LVL_HIGH;
      fr_q    <= 3'b000;
      afr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fr_q    <= fr_d;
      afr_q   <= afr_d;
    end
  end

  // Next state from the accepted vector; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    fr_d    = fr_q;
    afr_d   = afr_q;
    if (accept_s) begin
      state_d = decode_level(acc_vec_s);
    end else begin
      state_d = state_q;
    end
    case (state_d)
      LVL_HIGH: begin fr_d = 3'b000; afr_d = 1'b0; end
      LVL_MID:  begin fr_d = 3'b001; afr_d = 1'b0; end
      LVL_LOW:  begin fr_d = 3'b011; afr_d = 1'b0; end
      LVL_CRIT: begin fr_d = 3'b111; afr_d = 1'b1; end
`ifdef FAULT_DETECT_EN
      FAULT:    begin fr_d = fr_q;   afr_d = 1'b1; end
`endif
      default:  begin fr_d = 3'b111; afr_d = 1'b1; end
    endcase
  end

  assign FR1 = fr_q[0];
  assign FR2 = fr_q[1];
  assign FR3 = fr_q[2];
  assign AFR = afr_q;

endmodule

// File: tb/tb_water_reservoir_controller.sv
// Table-driven bench for water_reservoir_controller (unfiltered and DEBOUNCE_CYCLES=3 instances).
module tb_water_reservoir_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic S1 = 1'b1, S2 = 1'b1, S3 = 1'b1;
  logic fr1_a, fr2_a, fr3_a, afr_a;
  logic fr1_b, fr2_b, fr3_b, afr_b;
  logic [3:0] out_a, out_b;

  always #5 clk = ~clk;

  water_reservoir_controller #(.DEBOUNCE_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .S1(S1), .S2(S2), .S3(S3),
    .FR1(fr1_a), .FR2(fr2_a), .FR3(fr3_a), .AFR(afr_a)
  );

  water_reservoir_controller #(.DEBOUNCE_CYCLES(3)) dut_db (
    .clk(clk), .reset(reset), .S1(S1), .S2(S2), .S3(S3),
    .FR1(fr1_b), .FR2(fr2_b), .FR3(fr3_b), .AFR(afr_b)
  );

  assign out_a = {fr1_a, fr2_a, fr3_a, afr_a};
  assign out_b = {fr1_b, fr2_b, fr3_b, afr_b};

  typedef struct {
    logic [2:0] s;    // {S3,S2,S1}
    logic [3:0] exp;  // {FR1,FR2,FR3,AFR}
  } vec_t;

  vec_t vecs[16];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic set_s(input logic [2:0] v);
    {S3, S2, S1} = v;
  endtask

  initial begin
    vecs[0]  = '{3'b011, 4'b1000};
    vecs[1]  = '{3'b001, 4'b1100};
    vecs[2]  = '{3'b000, 4'b1111};
    vecs[3]  = '{3'b001, 4'b1100};
`ifdef FAULT_DETECT_EN
    vecs[4]  = '{3'b101, 4'b1101};
    vecs[5]  = '{3'b111, 4'b0000};
    vecs[6]  = '{3'b010, 4'b0001};
    vecs[7]  = '{3'b110, 4'b0001};
    vecs[8]  = '{3'b100, 4'b0001};
    vecs[9]  = '{3'b011, 4'b1000};
    vecs[10] = '{3'b110, 4'b1001};
`else
    vecs[4]  = '{3'b101, 4'b1100};
    vecs[5]  = '{3'b111, 4'b0000};
    vecs[6]  = '{3'b010, 4'b1111};
    vecs[7]  = '{3'b110, 4'b1111};
    vecs[8]  = '{3'b100, 4'b1111};
    vecs[9]  = '{3'b011, 4'b1000};
    vecs[10] = '{3'b110, 4'b1111};
`endif
    vecs[11] = '{3'b000, 4'b1111};
    vecs[12] = '{3'b111, 4'b0000};
    vecs[13] = '{3'b000, 4'b1111};
    vecs[14] = '{3'b001, 4'b1100};
    vecs[15] = '{3'b011, 4'b1000};

    // Reset for one clock with the reservoir full.
    reset = 1'b0;
    set_s(3'b111);
    @(negedge clk);
    check("reset_a", out_a, 4'b0000);
    check("reset_b", out_b, 4'b0000);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_s(vecs[i].s);
      @(negedge clk);
      check($sformatf("vec%0d_s%b", i, vecs[i].s), out_a, vecs[i].exp);
    end

    // Outputs stay constant while the vector is unchanged.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d", i), out_a, 4'b1000);
    end

    // Reset overrides a simultaneous sensor change.
    reset = 1'b0;
    set_s(3'b000);
    @(negedge clk);
    check("rst_override", out_a, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_crit", out_a, 4'b1111);

    // Re-sync both instances at LVL_HIGH.
    reset = 1'b0;
    set_s(3'b111);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 2-clk glitch to 000 is ignored by the debounced instance.
    set_s(3'b000);
    @(negedge clk);
    check("glitch_fast", out_a, 4'b1111);
    @(negedge clk);
    set_s(3'b111);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("glitch_db%0d", i), out_b, 4'b0000);
    end

    // Stable 000 is accepted after DEBOUNCE_CYCLES+1 clocks.
    set_s(3'b000);
    @(negedge clk);
    check("db_lat1", out_b, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check("db_lat3", out_b, 4'b0000);
    @(negedge clk);
    check("db_lat4", out_b, 4'b1111);

    // Restart: a change mid-count delays acceptance.
    set_s(3'b001);
    @(negedge clk);
    @(negedge clk);
    set_s(3'b011);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("db_restart3", out_b, 4'b1111);
    @(negedge clk);
    check("db_restart4", out_b, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
